conv2_ctrl: RTL

//  Sequencer for the C3 (conv2) layer. Walks the 10x10 output positions. For each position it

---
 rtl/lenet_pkg.sv | 30 +++
 rtl/conv_addr_gen.sv | 107 ++++++++++
 rtl/conv2_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet layer constants, C3 sequencer state and tap tag types
package lenet_pkg;

  // C3 (conv2) geometry
  localparam int C3_IN_DIM    = 14;
  localparam int C3_K         = 5;
  localparam int C3_OUT_DIM   = C3_IN_DIM - C3_K + 1;
  localparam int C3_RD_LAT    = 1;
  localparam int C3_EXEC_LAT  = 2;
  localparam int C3_WR_STAGES = 1 + C3_EXEC_LAT;

  localparam int S2_AW = 8;
  localparam int F4_AW = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // Tag travelling alongside each S2 read until the data reaches the MAC array
  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [F4_AW-1:0] waddr;
  } tap_tag_t;

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - C3 window/tap counters with incremental S2 read address
module conv_addr_gen
  import lenet_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [S2_AW-1:0] s2_raddr,
  output logic             first_tap,
  output logic             last_tap,
  output logic             last_window,
  output logic [F4_AW-1:0] win_idx
);

  localparam logic [2:0]       KC_MAX   = 3'(C3_K - 1);
  localparam logic [3:0]       POS_MAX  = 4'(C3_OUT_DIM - 1);
  localparam logic [F4_AW-1:0] WIN_MAX  = F4_AW'(C3_OUT_DIM * C3_OUT_DIM - 1);
  // Offset jump from the end of one kernel row to the start of the next
  localparam logic [S2_AW-1:0] KR_STEP  = S2_AW'(C3_IN_DIM - C3_K + 1);
  // Base jump at a row wrap: the normal +1 column step plus K-1 to skip the kernel overhang
  localparam logic [S2_AW-1:0] ROW_STEP = S2_AW'(1 + (C3_K - 1));

  logic [2:0]       kc_q, kc_d, kr_q, kr_d;
  logic [3:0]       col_q, col_d, row_q, row_d;
  logic [S2_AW-1:0] base_q, base_d, off_q, off_d;
  logic [F4_AW-1:0] widx_q, widx_d;

  // Advance the tap/window counters and the base/offset address terms on each issued read
  always_comb begin
    kc_d   = kc_q;
    kr_d   = kr_q;
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    off_d  = off_q;
    widx_d = widx_q;
    if (clr) begin
      kc_d   = '0;
      kr_d   = '0;
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
      off_d  = '0;
      widx_d = '0;
    end else if (adv) begin
      if (kc_q != KC_MAX) begin
        kc_d  = kc_q + 3'd1;
        off_d = off_q + S2_AW'(1);
      end else begin
        kc_d = '0;
        if (kr_q != KC_MAX) begin
          kr_d  = kr_q + 3'd1;
          off_d = off_q + KR_STEP;
        end else begin
          kr_d   = '0;
          off_d  = '0;
          widx_d = (widx_q == WIN_MAX) ? '0 : widx_q + F4_AW'(1);
          if (col_q != POS_MAX) begin
            col_d  = col_q + 4'd1;
            base_d = base_q + S2_AW'(1);
          end else begin
            col_d = '0;
            if (row_q != POS_MAX) begin
              row_d  = row_q + 4'd1;
              base_d = base_q + ROW_STEP;
            end else begin
              row_d  = '0;
              base_d = '0;
            end
          end
        end
      end
    end
  end

  // Counter and address-term registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_q   <= '0;
      kr_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
      off_q  <= '0;
      widx_q <= '0;
    end else begin
      kc_q   <= kc_d;
      kr_q   <= kr_d;
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      off_q  <= off_d;
      widx_q <= widx_d;
    end
  end

  // Address and position flags for the tap currently presented
  always_comb begin
    s2_raddr    = base_q + off_q;
    first_tap   = (kc_q == '0) && (kr_q == '0);
    last_tap    = (kc_q == KC_MAX) && (kr_q == KC_MAX);
    last_window = (col_q == POS_MAX) && (row_q == POS_MAX);
    win_idx     = widx_q;
  end

endmodule

// File: rtl/conv2_ctrl.sv
// rtl/conv2_ctrl.sv - C3 (conv2) layer sequencer: S2 tap reads, MAC control, F4 writes
module conv2_ctrl
  import lenet_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             s2_gnt,
  output logic             s2_re,
  output logic [S2_AW-1:0] s2_raddr,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             f4_we,
  output logic [F4_AW-1:0] f4_waddr
);

  conv_state_e state_q, state_d;

  tap_tag_t tap_q [C3_RD_LAT];
  tap_tag_t tap_d [C3_RD_LAT];
  tap_tag_t tap_out;

  logic [C3_WR_STAGES-1:0] wr_v_q, wr_v_d;
  logic [F4_AW-1:0]        wr_a_q [C3_WR_STAGES];
  logic [F4_AW-1:0]        wr_a_d [C3_WR_STAGES];

  logic             first_tap, last_tap, last_window, pipe_idle;
  logic [F4_AW-1:0] win_idx;

  conv_addr_gen u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (state_q == ST_IDLE),
    .adv         (s2_re),
    .s2_raddr    (s2_raddr),
    .first_tap   (first_tap),
    .last_tap    (last_tap),
    .last_window (last_window),
    .win_idx     (win_idx)
  );

  // Pipelines hold nothing beyond the final F4 write stage, so the next cycle ends the drain
  always_comb begin
    pipe_idle = (wr_v_q[C3_WR_STAGES-2:0] == '0);
    for (int i = 0; i < C3_RD_LAT; i++) begin
      if (tap_q[i].valid) pipe_idle = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (s2_re && last_tap && last_window) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_idle) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM and pipeline-driven outputs
  always_comb begin
    busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done     = (state_q == ST_DONE);
    s2_re    = (state_q == ST_RUN) && s2_gnt;
    tap_out  = tap_q[C3_RD_LAT-1];
    mac_en   = tap_out.valid;
    mac_clr  = tap_out.valid && tap_out.first;
    f4_we    = wr_v_q[C3_WR_STAGES-1];
    f4_waddr = wr_a_q[C3_WR_STAGES-1];
  end

  // Tap tag follows the S2 read latency; a stalled cycle enters as a bubble
  always_comb begin
    tap_d[0].valid = s2_re;
    tap_d[0].first = first_tap;
    tap_d[0].last  = last_tap;
    tap_d[0].waddr = win_idx;
    for (int i = 1; i < C3_RD_LAT; i++) tap_d[i] = tap_q[i-1];
  end

  // Write tag enters when the last tap of a window reaches the MAC, then shifts freely
  always_comb begin
    wr_v_d    = {wr_v_q[C3_WR_STAGES-2:0], tap_out.valid & tap_out.last};
    wr_a_d[0] = tap_out.waddr;
    for (int i = 1; i < C3_WR_STAGES; i++) wr_a_d[i] = wr_a_q[i-1];
  end

  // Tap and write delay-line registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C3_RD_LAT; i++) tap_q[i] <= '0;
      wr_v_q <= '0;
      for (int i = 0; i < C3_WR_STAGES; i++) wr_a_q[i] <= '0;
    end else begin
      for (int i = 0; i < C3_RD_LAT; i++) tap_q[i] <= tap_d[i];
      wr_v_q <= wr_v_d;
      for (int i = 0; i < C3_WR_STAGES; i++) wr_a_q[i] <= wr_a_d[i];
    end
  end

endmodule
